// File: rtl/alu_seq_vector_if.sv
// Operation/result bus for alu_seq_vector: operands and opcode in, result and flags out.
// No storage; pure wiring bundle.
// valid/ready on both the operation side and the result side.
interface alu_seq_vector_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       CTRL;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             OVF;
  logic             ZERO;

  // Producer of operations and consumer of results
  modport master (
    output in_valid, A, B, CTRL, out_ready,
    input  in_ready, out_valid, C, OVF, ZERO
  );

  // The ALU itself
  modport slave (
    input  in_valid, A, B, CTRL, out_ready,
    output in_ready, out_valid, C, OVF, ZERO
  );
endinterface

// File: rtl/alu_seq_vector.sv
// Sequential ALU: ADD/SUB/AND/GT/OR/XOR/SHL in one step, MUL as WIDTH-step shift-add.
// Latency: result valid 1 cycle after accept, WIDTH+1 cycles for MUL.
// One op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module alu_seq_vector #(
  parameter int WIDTH = 4
) (
`ifdef USE_POWER_PINS
  inout wire              vccd1,
  inout wire              vssd1,
`endif
  input  logic            clk,
  input  logic            rst_n,
  alu_seq_vector_if.slave bus
);

  localparam int              CW    = $clog2(WIDTH) + 1;
  localparam logic [WIDTH:0]  W_VAL = (WIDTH+1)'(WIDTH);
  localparam logic [CW-1:0]   LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] shl_wide;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   alu_c;
  logic               alu_ovf;

  // Single-cycle result straight from the bus; only consumed on an accept edge
  always_comb begin
    sum      = {1'b0, bus.A} + {1'b0, bus.B};
    // Zero-extended subtract: the top bit is the borrow (A < B)
    diff     = {1'b0, bus.A} - {1'b0, bus.B};
    // Double-width shift so bits pushed past the result are visible for OVF
    shl_wide = {{WIDTH{1'b0}}, bus.A} << bus.B;
    alu_c    = '0;
    alu_ovf  = 1'b0;
    case (bus.CTRL)
      3'd0: begin alu_c = sum[WIDTH-1:0];  alu_ovf = sum[WIDTH];  end
      3'd1: begin alu_c = diff[WIDTH-1:0]; alu_ovf = diff[WIDTH]; end
      3'd2: alu_c = bus.A & bus.B;
      3'd3: alu_c = {{(WIDTH-1){1'b0}}, (bus.A > bus.B)};
      3'd4: alu_c = bus.A | bus.B;
      3'd5: alu_c = bus.A ^ bus.B;
      3'd6: begin
        // Shifting by WIDTH or more pushes out every bit of A
        if ({1'b0, bus.B} >= W_VAL) begin
          alu_c   = '0;
          alu_ovf = |bus.A;
        end else begin
          alu_c   = shl_wide[WIDTH-1:0];
          alu_ovf = |shl_wide[2*WIDTH-1:WIDTH];
        end
      end
      default: ;
    endcase
  end

  // Next-state: accept in IDLE, one multiplier bit per BUSY cycle, hold in DONE
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.CTRL == 3'd7) begin
            state_d  = BUSY;
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d  = DONE;
            c_d      = alu_c;
            ovf_d    = alu_ovf;
            zero_d   = (alu_c == '0);
          end
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          c_d     = acc_step[WIDTH-1:0];
          ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
          zero_d  = (acc_step[WIDTH-1:0] == '0);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state; reset aborts any op in flight and clears the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      c_q      <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.C         = c_q;
  assign bus.OVF       = ovf_q;
  assign bus.ZERO      = zero_q;

endmodule
